// File: rtl/adc_seq_avg.sv
// adc_seq_avg: multi-channel ADC sweep sequencer with per-slot moving-average
// filters. One sweep per accepted SYNC_TR: each slot issues a command to the
// ADC core, waits for the matching response (or a timeout), then updates that
// slot's filter. Sticky flags report channel mismatches and timeouts.

// One slot's moving-average state: running sum, history window, write pointer.
// The history lives in flops, so the asynchronous reset clears the whole window
// in a single step and no separate clearing sweep is needed.
module adc_seq_avg_lane #(
   parameter  int DATA_W   = 12,
   parameter  int AVG_LOG2 = 3,
   localparam int SUM_W    = DATA_W + AVG_LOG2,
   localparam int DEPTH    = 1 << AVG_LOG2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              upd,
   input  logic [DATA_W-1:0] din,
   output logic [SUM_W-1:0]  sum_nxt
);

   logic [DEPTH-1:0][DATA_W-1:0] hist_q, hist_d;
   logic [SUM_W-1:0]             sum_q, sum_d;
   logic [AVG_LOG2-1:0]          wptr_q, wptr_d;

   // Running sum replaces the oldest sample; the sum can never go negative
   // because the evicted sample is always part of the current sum.
   always_comb begin
      sum_nxt = sum_q + SUM_W'(din) - SUM_W'(hist_q[wptr_q]);
      sum_d   = sum_q;
      hist_d  = hist_q;
      wptr_d  = wptr_q;
      if (upd) begin
         sum_d          = sum_nxt;
         hist_d[wptr_q] = din;
         wptr_d         = wptr_q + 1'b1;
      end
   end

   // Filter state registers, zeroed by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist_q <= '0;
         sum_q  <= '0;
         wptr_q <= '0;
      end else begin
         hist_q <= hist_d;
         sum_q  <= sum_d;
         wptr_q <= wptr_d;
      end
   end

endmodule

module adc_seq_avg #(
   parameter  int NUM_CH   = 4,
   parameter  int DATA_W   = 12,
   parameter  int CH_W     = 5,
   parameter  int AVG_LOG2 = 3,
   parameter  int TIMEOUT  = 1023,
   localparam int SLOT_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int TMO_W    = $clog2(TIMEOUT + 1),
   localparam int SUM_W    = DATA_W + AVG_LOG2
) (
   input  logic                   SYS_CLK,
   input  logic                   RESET_n,
   input  logic                   ENABLE,
   input  logic                   SYNC_TR,
   input  logic                   FILTER_EN,
   input  logic [NUM_CH*CH_W-1:0] CH_MAP,
   input  logic                   CLR_ERR,
   output logic                   CMD_VALID,
   output logic [CH_W-1:0]        CMD_CHANNEL,
   input  logic                   CMD_READY,
   input  logic                   RSP_VALID,
   input  logic [CH_W-1:0]        RSP_CHANNEL,
   input  logic [DATA_W-1:0]      RSP_DATA,
   output logic                   OUT_VALID,
   output logic [SLOT_W-1:0]      OUT_SLOT,
   output logic [DATA_W-1:0]      OUT_DATA,
   output logic                   SWEEP_DONE,
   output logic                   BUSY,
   output logic                   ERR_MISMATCH,
   output logic                   ERR_TIMEOUT
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_UPDATE,
      S_NEXT
   } state_t;

   state_t                     state_q, state_d;
   logic [SLOT_W-1:0]          slot_q, slot_d;
   logic [TMO_W-1:0]           tmo_q, tmo_d;
   logic                       cmd_valid_q, cmd_valid_d;
   logic [CH_W-1:0]            cmd_channel_q, cmd_channel_d;
   logic                       out_valid_q, out_valid_d;
   logic [SLOT_W-1:0]          out_slot_q, out_slot_d;
   logic [DATA_W-1:0]          out_data_q, out_data_d;
   logic                       sweep_done_q, sweep_done_d;
   logic                       busy_q, busy_d;
   logic                       err_mm_q, err_mm_d;
   logic                       err_to_q, err_to_d;

   logic [NUM_CH-1:0][CH_W-1:0]  ch_map;
   logic [NUM_CH-1:0]            lane_upd;
   logic [NUM_CH-1:0][SUM_W-1:0] lane_sum;
   logic [SUM_W-1:0]             sel_sum;
   logic                         rsp_hit;
   logic                         mm_hit;
   logic                         to_hit;

   assign ch_map  = CH_MAP;
   assign sel_sum = lane_sum[slot_q];
   // A response is only accepted while waiting and only if it is for the
   // channel this slot commanded.
   assign rsp_hit = (state_q == S_WAIT) && RSP_VALID && (RSP_CHANNEL == ch_map[slot_q]);

   // One filter per slot; only the active slot's lane updates.
   for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
      assign lane_upd[g] = rsp_hit && (slot_q == SLOT_W'(g));
      adc_seq_avg_lane #(
         .DATA_W   (DATA_W),
         .AVG_LOG2 (AVG_LOG2)
      ) u_lane (
         .clk     (SYS_CLK),
         .rst_n   (RESET_n),
         .upd     (lane_upd[g]),
         .din     (RSP_DATA),
         .sum_nxt (lane_sum[g])
      );
   end

   // Sequencer next state and next registered outputs. The result is
   // registered on the edge that accepts the response, so OUT_VALID appears
   // the cycle after RSP_VALID and coincides with the UPDATE state.
   always_comb begin
      state_d       = state_q;
      slot_d        = slot_q;
      tmo_d         = tmo_q;
      cmd_valid_d   = cmd_valid_q;
      cmd_channel_d = cmd_channel_q;
      out_valid_d   = 1'b0;
      out_slot_d    = out_slot_q;
      out_data_d    = out_data_q;
      sweep_done_d  = 1'b0;
      mm_hit        = 1'b0;
      to_hit        = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (ENABLE && SYNC_TR) begin
               state_d       = S_ISSUE;
               slot_d        = '0;
               cmd_valid_d   = 1'b1;
               cmd_channel_d = ch_map[0];
            end
         end
         S_ISSUE: begin
            // Command held stable until the core takes it.
            if (CMD_READY) begin
               state_d     = S_WAIT;
               cmd_valid_d = 1'b0;
               tmo_d       = '0;
            end
         end
         S_WAIT: begin
            if (RSP_VALID) begin
               if (rsp_hit) begin
                  state_d     = S_UPDATE;
                  out_valid_d = 1'b1;
                  out_slot_d  = slot_q;
                  out_data_d  = FILTER_EN ? DATA_W'(sel_sum >> AVG_LOG2) : RSP_DATA;
               end else begin
                  mm_hit  = 1'b1;
                  state_d = S_NEXT;
               end
            end else begin
               tmo_d = tmo_q + 1'b1;
               if (tmo_d == TMO_W'(TIMEOUT)) begin
                  to_hit  = 1'b1;
                  state_d = S_NEXT;
               end
            end
         end
         S_UPDATE: begin
            state_d = S_NEXT;
         end
         S_NEXT: begin
            if (slot_q == SLOT_W'(NUM_CH - 1)) begin
               sweep_done_d = 1'b1;
               state_d      = S_IDLE;
            end else if (ENABLE) begin
               slot_d        = slot_q + 1'b1;
               state_d       = S_ISSUE;
               cmd_valid_d   = 1'b1;
               cmd_channel_d = ch_map[slot_q + 1'b1];
            end else begin
               // Partial sweep abandoned: no SWEEP_DONE.
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d     = S_IDLE;
            cmd_valid_d = 1'b0;
         end
      endcase
      busy_d   = (state_d != S_IDLE);
      // A new error in the same cycle as CLR_ERR keeps the flag set.
      err_mm_d = mm_hit | (err_mm_q & ~CLR_ERR);
      err_to_d = to_hit | (err_to_q & ~CLR_ERR);
   end

   // Sequencer state and registered outputs.
   always_ff @(posedge SYS_CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         state_q       <= S_IDLE;
         slot_q        <= '0;
         tmo_q         <= '0;
         cmd_valid_q   <= 1'b0;
         cmd_channel_q <= '0;
         out_valid_q   <= 1'b0;
         out_slot_q    <= '0;
         out_data_q    <= '0;
         sweep_done_q  <= 1'b0;
         busy_q        <= 1'b0;
         err_mm_q      <= 1'b0;
         err_to_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         slot_q        <= slot_d;
         tmo_q         <= tmo_d;
         cmd_valid_q   <= cmd_valid_d;
         cmd_channel_q <= cmd_channel_d;
         out_valid_q   <= out_valid_d;
         out_slot_q    <= out_slot_d;
         out_data_q    <= out_data_d;
         sweep_done_q  <= sweep_done_d;
         busy_q        <= busy_d;
         err_mm_q      <= err_mm_d;
         err_to_q      <= err_to_d;
      end
   end

   assign CMD_VALID    = cmd_valid_q;
   assign CMD_CHANNEL  = cmd_channel_q;
   assign OUT_VALID    = out_valid_q;
   assign OUT_SLOT     = out_slot_q;
   assign OUT_DATA     = out_data_q;
   assign SWEEP_DONE   = sweep_done_q;
   assign BUSY         = busy_q;
   assign ERR_MISMATCH = err_mm_q;
   assign ERR_TIMEOUT  = err_to_q;

endmodule

// File: tb/tb_adc_seq_avg.sv
// Randomised scoreboard bench for adc_seq_avg: a sliding-window average model
// predicts each result; a monitor pops and compares on every OUT_VALID.
module tb_adc_seq_avg;

   localparam int NUM_CH   = 2;
   localparam int DATA_W   = 12;
   localparam int CH_W     = 5;
   localparam int AVG_LOG2 = 2;
   localparam int TIMEOUT  = 15;
   localparam int WIN      = 1 << AVG_LOG2;

   logic                   SYS_CLK, RESET_n, ENABLE, SYNC_TR, FILTER_EN, CLR_ERR;
   logic [NUM_CH*CH_W-1:0] CH_MAP;
   logic                   CMD_VALID, CMD_READY, RSP_VALID;
   logic [CH_W-1:0]        CMD_CHANNEL, RSP_CHANNEL;
   logic [DATA_W-1:0]      RSP_DATA, OUT_DATA;
   logic                   OUT_VALID, SWEEP_DONE, BUSY, ERR_MISMATCH, ERR_TIMEOUT;
   logic [0:0]             OUT_SLOT;

   adc_seq_avg #(
      .NUM_CH(NUM_CH), .DATA_W(DATA_W), .CH_W(CH_W), .AVG_LOG2(AVG_LOG2), .TIMEOUT(TIMEOUT)
   ) dut (
      .SYS_CLK(SYS_CLK), .RESET_n(RESET_n), .ENABLE(ENABLE), .SYNC_TR(SYNC_TR),
      .FILTER_EN(FILTER_EN), .CH_MAP(CH_MAP), .CLR_ERR(CLR_ERR),
      .CMD_VALID(CMD_VALID), .CMD_CHANNEL(CMD_CHANNEL), .CMD_READY(CMD_READY),
      .RSP_VALID(RSP_VALID), .RSP_CHANNEL(RSP_CHANNEL), .RSP_DATA(RSP_DATA),
      .OUT_VALID(OUT_VALID), .OUT_SLOT(OUT_SLOT), .OUT_DATA(OUT_DATA),
      .SWEEP_DONE(SWEEP_DONE), .BUSY(BUSY), .ERR_MISMATCH(ERR_MISMATCH),
      .ERR_TIMEOUT(ERR_TIMEOUT)
   );

   typedef struct {
      int          slot;
      int unsigned data;
      longint      cyc;
   } exp_t;

   exp_t        sbq[$];
   int unsigned mwin[NUM_CH][WIN];
   int          checks = 0;
   int          errors = 0;
   longint      cyc = 0;

   initial begin
      SYS_CLK = 1'b0;
      forever #5 SYS_CLK = ~SYS_CLK;
   end

   initial forever begin
      @(posedge SYS_CLK);
      cyc++;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(negedge SYS_CLK);
   endtask

   function automatic logic [CH_W-1:0] chmap(input int s);
      return CH_MAP[s*CH_W +: CH_W];
   endfunction

   // Reference: output is the mean of the last WIN samples of the slot,
   // with missing samples treated as zero, truncated; or the raw sample.
   function automatic int unsigned model_apply(input int s, input int unsigned v, input bit filt);
      int unsigned tot = 0;
      for (int k = WIN - 1; k > 0; k--) mwin[s][k] = mwin[s][k-1];
      mwin[s][0] = v;
      for (int k = 0; k < WIN; k++) tot += mwin[s][k];
      return filt ? tot / WIN : v;
   endfunction

   task automatic model_clear();
      for (int s = 0; s < NUM_CH; s++)
         for (int k = 0; k < WIN; k++) mwin[s][k] = 0;
   endtask

   // Monitor: every OUT_VALID must match the oldest expected result.
   initial forever begin
      exp_t e;
      tick();
      if (RESET_n && OUT_VALID) begin
         if (sbq.size() == 0) chk("unexpected_out_valid", OUT_VALID, 0);
         else begin
            e = sbq.pop_front();
            chk("out_slot", OUT_SLOT, e.slot);
            chk("out_data", OUT_DATA, e.data);
            chk("out_latency_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic do_reset();
      tick();
      RESET_n = 1'b0; CMD_READY = 1'b0; RSP_VALID = 1'b0; SYNC_TR = 1'b0; CLR_ERR = 1'b0;
      #1;
      chk("rst_cmd_valid", CMD_VALID, 0);
      chk("rst_cmd_channel", CMD_CHANNEL, 0);
      chk("rst_out_valid", OUT_VALID, 0);
      chk("rst_out_data", OUT_DATA, 0);
      chk("rst_out_slot", OUT_SLOT, 0);
      chk("rst_sweep_done", SWEEP_DONE, 0);
      chk("rst_busy", BUSY, 0);
      chk("rst_err_mismatch", ERR_MISMATCH, 0);
      chk("rst_err_timeout", ERR_TIMEOUT, 0);
      repeat (2) tick();
      model_clear();
      sbq.delete();
      RESET_n = 1'b1;
      tick();
   endtask

   // Wait for the slot's command, optionally stall it, then complete the handshake.
   task automatic wait_cmd(input int s, input int bp, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (CMD_VALID) begin ok = 1'b1; break; end
         tick();
      end
      chk("cmd_valid_seen", ok, 1);
      if (!ok) return;
      chk("cmd_channel", CMD_CHANNEL, chmap(s));
      for (int i = 0; i < bp; i++) begin
         // A matching response while the command is stalled must be ignored.
         RSP_VALID = 1'b1; RSP_CHANNEL = chmap(s); RSP_DATA = DATA_W'($urandom);
         tick();
         chk("bp_cmd_valid", CMD_VALID, 1);
         chk("bp_cmd_channel", CMD_CHANNEL, chmap(s));
      end
      RSP_VALID = 1'b0;
      CMD_READY = 1'b1;
      tick();
      CMD_READY = 1'b0;
      chk("cmd_dropped_after_hs", CMD_VALID, 0);
   endtask

   // mode 0: matching response, 1: wrong channel (with CLR_ERR), 2: silence.
   task automatic respond(input int s, input int mode, input int unsigned v, input bit filt);
      int n;
      bit seen;
      case (mode)
         0: begin
            repeat ($urandom_range(0, 2)) tick();
            RSP_VALID = 1'b1; RSP_CHANNEL = chmap(s); RSP_DATA = DATA_W'(v);
            sbq.push_back('{s, model_apply(s, v, filt), cyc + 1});
            tick();
            RSP_VALID = 1'b0;
         end
         1: begin
            RSP_VALID = 1'b1; RSP_CHANNEL = 5'd7; RSP_DATA = DATA_W'(v); CLR_ERR = 1'b1;
            tick();
            RSP_VALID = 1'b0; CLR_ERR = 1'b0;
            chk("err_mismatch_set", ERR_MISMATCH, 1);
         end
         default: begin
            seen = 1'b0; n = 0;
            while (!seen && n < 40) begin
               tick(); n++;
               if (ERR_TIMEOUT) seen = 1'b1;
            end
            chk("err_timeout_set", seen, 1);
            chk("timeout_cycles", n, TIMEOUT);
         end
      endcase
   endtask

   task automatic sweep(input int mode[NUM_CH], input int unsigned val[NUM_CH],
                        input bit filt, input int bp, input bit drop_en);
      bit ok;
      int n;
      tick();
      FILTER_EN = filt; SYNC_TR = 1'b1; CLR_ERR = 1'b1;
      tick();
      SYNC_TR = 1'b0; CLR_ERR = 1'b0;
      chk("errs_cleared", ERR_MISMATCH | ERR_TIMEOUT, 0);
      for (int s = 0; s < NUM_CH; s++) begin
         wait_cmd(s, bp, ok);
         if (!ok) return;
         if (drop_en) ENABLE = 1'b0;
         respond(s, mode[s], val[s], filt);
         if (drop_en) begin
            n = 0;
            repeat (8) begin
               tick();
               if (SWEEP_DONE || CMD_VALID) n++;
            end
            chk("drop_no_done_or_cmd", n, 0);
            chk("drop_busy", BUSY, 0);
            ENABLE = 1'b1;
            return;
         end
      end
      ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (SWEEP_DONE) begin ok = 1'b1; break; end
      end
      chk("sweep_done_seen", ok, 1);
      chk("busy_at_done", BUSY, 0);
      tick();
      chk("sweep_done_pulse", SWEEP_DONE, 0);
   endtask

   int          m_norm[NUM_CH] = '{0, 0};
   int unsigned vals[NUM_CH];
   int          modes[NUM_CH];
   bit          ok;

   initial begin
      RESET_n = 1'b0; ENABLE = 1'b1; SYNC_TR = 1'b0; FILTER_EN = 1'b1; CLR_ERR = 1'b0;
      CH_MAP = {5'd3, 5'd1};
      CMD_READY = 1'b0; RSP_VALID = 1'b0; RSP_CHANNEL = '0; RSP_DATA = '0;
      model_clear();
      do_reset();

      // Filtered ramp on slot 0: 25, 75, 150, 250, 350.
      for (int i = 1; i <= 5; i++) sweep(m_norm, '{100 * i, $urandom_range(0, 4095)}, 1'b1, 0, 1'b0);
      // Raw ramp, then back to filtered with 600 -> (300+400+500+600)/4 = 450.
      for (int i = 1; i <= 5; i++) sweep(m_norm, '{100 * i, $urandom_range(0, 4095)}, 1'b0, 0, 1'b0);
      sweep(m_norm, '{600, $urandom_range(0, 4095)}, 1'b1, 0, 1'b0);

      // Command backpressure.
      sweep(m_norm, '{$urandom_range(0, 4095), $urandom_range(0, 4095)}, 1'b1, 10, 1'b0);

      // Mismatch on slot 0, slot 1 still runs; then explicit clear.
      sweep('{1, 0}, '{123, $urandom_range(0, 4095)}, 1'b1, 0, 1'b0);
      tick(); CLR_ERR = 1'b1; tick(); CLR_ERR = 1'b0;
      chk("clr_err_mismatch", ERR_MISMATCH, 0);

      // Timeout on slot 0; following sweep proves the filter was left alone.
      sweep('{2, 0}, '{0, $urandom_range(0, 4095)}, 1'b1, 0, 1'b0);
      sweep(m_norm, '{$urandom_range(0, 4095), $urandom_range(0, 4095)}, 1'b1, 0, 1'b0);

      // Stray responses in IDLE produce nothing.
      for (int i = 0; i < 3; i++) begin
         RSP_VALID = 1'b1; RSP_CHANNEL = chmap(i % NUM_CH); RSP_DATA = DATA_W'($urandom);
         tick();
         chk("idle_rsp_no_out", OUT_VALID, 0);
         chk("idle_rsp_not_busy", BUSY, 0);
      end
      RSP_VALID = 1'b0;

      // ENABLE dropped during slot 0.
      sweep(m_norm, '{$urandom_range(0, 4095), 0}, 1'b1, 0, 1'b1);

      // Randomised sweeps.
      for (int i = 0; i < 20; i++) begin
         for (int s = 0; s < NUM_CH; s++) begin
            n_pick(modes[s]);
            vals[s] = $urandom_range(0, 4095);
         end
         sweep(modes, vals, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0);
      end

      // Reset while waiting for a response, then restart from an empty filter.
      tick(); SYNC_TR = 1'b1; tick(); SYNC_TR = 1'b0;
      wait_cmd(0, 0, ok);
      tick();
      chk("mid_wait_busy", BUSY, 1);
      do_reset();
      sweep(m_norm, '{1000, 2000}, 1'b1, 0, 1'b0);

      repeat (4) tick();
      chk("scoreboard_drained", sbq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   task automatic n_pick(output int m);
      int r;
      r = $urandom_range(0, 9);
      m = (r == 0) ? 1 : (r == 1) ? 2 : 0;
   endtask

endmodule
